// File: rtl/led_uart_reporter.sv
// led_uart_reporter: watches the MiniAlu LED bus and reports every change as an 8N1 UART frame.
// Each new LED value is queued in a small FIFO and sent LSB first on a single TX pin.
//
// Ports:
//   Clock      - system clock, rising edge
//   Reset      - asynchronous, active-low reset
//   iLed       - LED value from the ALU, synchronous to Clock
//   oTx        - UART serial output, idles high, driven from a register
//   oBusy      - a frame is in flight or the FIFO holds data
//   oOverflow  - sticky: a change was dropped because the FIFO was full
//   oFifoCount - number of queued entries
module led_uart_reporter #(
  parameter int unsigned CLKS_PER_BIT = 434,  // >= 2
  parameter int unsigned FIFO_DEPTH   = 8     // power of 2, >= 2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [7:0]                  iLed,
  output logic                        oTx,
  output logic                        oBusy,
  output logic                        oOverflow,
  output logic [$clog2(FIFO_DEPTH):0] oFifoCount
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CntW-1:0]  Full     = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Change detect and FIFO state
  logic [7:0]      prev_led_q, prev_led_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  // Transmitter state
  state_e          state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic push, pop, full, wr_en, baud_wrap;

  // FIFO bookkeeping
  always_comb begin
    push  = (iLed != prev_led_q);
    pop   = (state_q == StIdle) && (count_q != '0);
    full  = (count_q == Full);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    wr_en = push && (!full || pop);

    prev_led_d = push ? iLed : prev_led_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    ovf_d      = ovf_q | (push && full && !pop);

    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM; tx_d is the level oTx takes after this edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    baud_wrap = (baud_q == BaudLast);

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_wrap) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_wrap) begin
          baud_d    = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            // Next data bit is the one that lands in shift[0] after the shift.
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prev_led_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      prev_led_q <= prev_led_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= iLed;
      end
    end
  end

  assign oTx        = tx_q;
  assign oBusy      = (state_q != StIdle) || (count_q != '0);
  assign oOverflow  = ovf_q;
  assign oFifoCount = count_q;

endmodule

// File: tb/tb_led_uart_reporter.sv
// Directed bench for led_uart_reporter with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A free-running monitor decodes UART frames into rx_q and logs frame start cycles.
module tb_led_uart_reporter;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led = 8'h00;
  logic       tx, busy, ovf;
  logic [3:0] cnt;

  led_uart_reporter #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .Clock      (clk),
    .Reset      (rst_n),
    .iLed       (led),
    .oTx        (tx),
    .oBusy      (busy),
    .oOverflow  (ovf),
    .oFifoCount (cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rx_q[$];
  int unsigned start_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick_n(1);
      n++;
    end
    check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    if (rx_q.size() != 0) got = rx_q.pop_front();
    else got = 8'hxx;
    check_val(tag, {24'd0, got}, {24'd0, exp});
  endtask

  // UART monitor: sample each bit in its middle cycle.
  logic [7:0] mon_byte;
  initial begin
    forever begin
      tick_n(1);
      if (rst_n && tx === 1'b0) begin
        start_q.push_back(cyc);
        tick_n(Cpb / 2);
        check_val("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          tick_n(Cpb);
          mon_byte[i] = tx;
        end
        tick_n(Cpb);
        check_val("stop_bit", {31'd0, tx}, 32'd1);
        rx_q.push_back(mon_byte);
      end
    end
  end

  logic all_high, any_busy;
  int unsigned t_start;

  initial begin
    // Reset and idle hold
    rst_n = 1'b0;
    led   = 8'h00;
    tick_n(3);
    check_val("rst_tx", {31'd0, tx}, 32'd1);
    check_val("rst_cnt", {28'd0, cnt}, 32'd0);
    rst_n = 1'b1;
    all_high = 1'b1;
    any_busy = 1'b0;
    repeat (100) begin
      tick_n(1);
      all_high &= tx;
      any_busy |= busy;
    end
    check_val("idle_tx_high", {31'd0, all_high}, 32'd1);
    check_val("idle_busy", {31'd0, any_busy}, 32'd0);
    check_val("idle_cnt", {28'd0, cnt}, 32'd0);
    check_val("idle_ovf", {31'd0, ovf}, 32'd0);

    // Single frame A5: latency and 40-cycle frame length
    led = 8'hA5;
    tick_n(1);
    check_val("a5_cnt_k", {28'd0, cnt}, 32'd1);
    check_val("a5_tx_k", {31'd0, tx}, 32'd1);
    check_val("a5_busy_k", {31'd0, busy}, 32'd1);
    tick_n(1);
    check_val("a5_tx_k1", {31'd0, tx}, 32'd0);
    check_val("a5_cnt_k1", {28'd0, cnt}, 32'd0);
    t_start = cyc;
    wait_idle("a5");
    check_val("a5_len", cyc - t_start, 32'd40);
    expect_rx("a5_byte", 8'hA5);
    start_q.delete();

    // Burst 01..0C: 01 popped, 02..09 queued, 0A..0C dropped
    for (int v = 1; v <= 12; v++) begin
      led = 8'(v);
      tick_n(1);
    end
    check_val("burst_cnt", {28'd0, cnt}, 32'd8);
    check_val("burst_ovf", {31'd0, ovf}, 32'd1);
    wait_idle("burst");
    check_val("burst_nframes", rx_q.size(), 32'd9);
    for (int v = 1; v <= 9; v++) begin
      expect_rx("burst_byte", 8'(v));
    end
    check_val("burst_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset clears overflow; then three back-to-back frames
    rst_n = 1'b0;
    led   = 8'h00;
    tick_n(2);
    check_val("rst2_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    rx_q.delete();
    start_q.delete();
    led = 8'h11; tick_n(1);
    led = 8'h22; tick_n(1);
    led = 8'h33; tick_n(1);
    wait_idle("b2b");
    check_val("b2b_tx_after", {31'd0, tx}, 32'd1);
    expect_rx("b2b_0", 8'h11);
    expect_rx("b2b_1", 8'h22);
    expect_rx("b2b_2", 8'h33);
    check_val("b2b_nstarts", start_q.size(), 32'd3);
    if (start_q.size() == 3) begin
      check_val("b2b_gap01", start_q[1] - start_q[0], 32'd41);
      check_val("b2b_gap12", start_q[2] - start_q[1], 32'd41);
    end

    // Reset during DATA bit 3
    led = 8'h5A; tick_n(1);
    led = 8'h66; tick_n(1);
    check_val("mid_tx_start", {31'd0, tx}, 32'd0);
    tick_n(17);
    check_val("mid_bit3", {31'd0, tx}, 32'd1);
    check_val("mid_cnt", {28'd0, cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_tx", {31'd0, tx}, 32'd1);
    check_val("mid_rst_cnt", {28'd0, cnt}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    led = 8'h00;
    tick_n(3);
    rst_n = 1'b1;
    all_high = 1'b1;
    any_busy = 1'b0;
    repeat (60) begin
      tick_n(1);
      all_high &= tx;
      any_busy |= busy;
    end
    check_val("post_rst_tx", {31'd0, all_high}, 32'd1);
    check_val("post_rst_busy", {31'd0, any_busy}, 32'd0);
    rx_q.delete();
    start_q.delete();

    // Only real changes are reported
    led = 8'h3C;
    tick_n(1);
    wait_idle("3c");
    expect_rx("3c_first", 8'h3C);
    tick_n(3);
    check_val("hold_cnt", {28'd0, cnt}, 32'd0);
    check_val("hold_busy", {31'd0, busy}, 32'd0);
    led = 8'hC3; tick_n(1);
    led = 8'h3C; tick_n(1);
    check_val("tog_cnt", {28'd0, cnt}, 32'd1);
    wait_idle("tog");
    expect_rx("tog_c3", 8'hC3);
    expect_rx("tog_3c", 8'h3C);
    check_val("tog_extra", rx_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_uart_reporter.md
Name: led_uart_reporter

Overview:
- Downstream consumer of the MiniAlu LED output bus.
- Detects every change of the 8-bit LED value and queues each new value in a small FIFO.
- Serialises queued values as 8N1 UART frames on a single TX pin, so LED program traces can be logged from a host PC.
- Sits between the ALU's oLed output and the board's UART TX pin, in the same clock domain as the ALU.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2.

Ports:
- Clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- iLed  input  8  LED value driven by the ALU, synchronous to Clock.
- oTx  output  1  UART serial output; idles high.
- oBusy  output  1  high when a frame is in flight or the FIFO is non-empty.
- oOverflow  output  1  sticky flag: a change was dropped because the FIFO was full.
- oFifoCount  output  $clog2(FIFO_DEPTH)+1  number of entries currently queued.

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - rPrevLed=8'h00, FIFO empty, read/write pointers 0, oFifoCount=0;
  - FSM=IDLE, oTx=1, oBusy=0, oOverflow=0;
  - bit counter and baud counter 0.
- Reset asserted mid-frame aborts the frame immediately (oTx=1 at once). The queued data is lost.
- Change detect:
  - push = (iLed != rPrevLed).
  - On each rising edge with push=1, rPrevLed<=iLed, whether or not the FIFO accepts the value.
  - Consequence: after reset, a value of 8'h00 is not reported.
- FIFO write:
  - On a push edge with count<FIFO_DEPTH, write iLed at wr_ptr and advance wr_ptr, wrapping at FIFO_DEPTH.
- FIFO full:
  - A push with count==FIFO_DEPTH and no pop in the same cycle drops the value and sets oOverflow=1.
  - oOverflow stays set until reset.
  - Push and pop in the same cycle while full: push is accepted and count stays FIFO_DEPTH.
- Pop:
  - Occurs only in IDLE with count>0.
  - The head byte is loaded into the shift register and rd_ptr advances.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: oTx=1. If count>0: pop, go to START, baud counter=0. oTx=0 from this edge on.
  - START: oTx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: oTx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the bit index increments. After bit 7 go to STOP.
  - STOP: oTx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing:
  - Exactly 10*CLKS_PER_BIT cycles from oTx falling to the end of the stop bit.
  - Consecutive frames are separated by exactly one IDLE cycle (oTx=1). Frame period is therefore 10*CLKS_PER_BIT+1 cycles.
- Latency: if iLed changes before edge k, edge k writes the FIFO, edge k+1 pops, and oTx falls after edge k+1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- oTx is driven from a register; no combinational glitches.
- oBusy = (FSM!=IDLE) | (count!=0). It is registered-state derived, with no extra latency.
- iLed changing again while a frame is in flight only affects the FIFO. The shift register holds the popped byte until the frame ends.

Test Plan:
- Reset with iLed=8'h00, then hold for 100 cycles -> oTx=1 throughout, oBusy=0, oFifoCount=0, oOverflow=0.
- CLKS_PER_BIT=4; iLed 00->A5 before edge k -> oFifoCount=1 after edge k. oTx falls after edge k+1. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 then stop=1. Total low-to-stop-end duration is 40 cycles.
- Change iLed every cycle through 01..0C (12 values), FIFO_DEPTH=8 -> the first value is popped and 8 are queued. Values are accepted while a pop frees space; later ones are dropped with oOverflow=1. The UART output carries 01..09 in order and oOverflow stays 1 until reset.
- Push 3 values back-to-back, then wait -> three frames, each separated by exactly one cycle of oTx=1. oBusy falls after the last stop bit.
- Assert Reset (drive 0) during DATA bit 3 of a frame -> oTx=1, FSM=IDLE, oFifoCount=0 immediately. No frame follows reset release.
- iLed toggles 3C->3C (no change) and 3C->C3->3C -> only actual changes are queued: two frames, C3 then 3C.
